// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op encodings, FSM states and helpers for the mul/div sequencer.
package mdu_pkg;

    localparam int DIV_ITER = 32;
    localparam int CNT_W    = $clog2(DIV_ITER);

    typedef enum logic [2:0] {
        MDU_NONE  = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } mdu_state_e;

    // Magnitude of a 32-bit operand; unsigned ops pass straight through.
    function automatic logic [31:0] abs32(input logic [31:0] x, input logic sgn);
        return (sgn && x[31]) ? -x : x;
    endfunction

endpackage

// File: rtl/mdu_div_radix2.sv
// div_radix2: iterative restoring unsigned divider, one quotient bit per cycle.
module div_radix2
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic        done_o,
    output logic [31:0] quo_o,
    output logic [31:0] rem_o
);

    logic             run_q, run_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
    logic [32:0]      shl;
    logic             ge;

    // One shift-subtract step per cycle; the dividend shifts out of quo_q as quotient bits shift in.
    always_comb begin
        shl   = {rem_q, quo_q[31]};
        ge    = shl >= {1'b0, dvs_q};
        run_d = run_q;
        cnt_d = cnt_q;
        quo_d = quo_q;
        rem_d = rem_q;
        dvs_d = dvs_q;
        if (start_i) begin
            run_d = 1'b1;
            cnt_d = '0;
            quo_d = dividend_i;
            rem_d = '0;
            dvs_d = divisor_i;
        end else if (run_q) begin
            rem_d = ge ? 32'(shl - {1'b0, dvs_q}) : shl[31:0];
            quo_d = {quo_q[30:0], ge};
            cnt_d = cnt_q + CNT_W'(1);
            run_d = cnt_q != CNT_W'(DIV_ITER - 1);
        end
    end

    // Divider state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
            cnt_q <= '0;
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
        end else begin
            run_q <= run_d;
            cnt_q <= cnt_d;
            quo_q <= quo_d;
            rem_q <= rem_d;
            dvs_q <= dvs_d;
        end
    end

    assign done_o = run_q && cnt_q == CNT_W'(DIV_ITER - 1);
    assign quo_o  = quo_q;
    assign rem_o  = rem_q;

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: E-stage mul/div sequencer (optional early-out divide: MDU_DIV_FAST_EN).
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [2:0]  op_e,
    input  logic [31:0] src_a_e,
    input  logic [31:0] src_b_e,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        hilo_we_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        busy_o
);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic             neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
    logic             mul_q, mul_d, fast_q, fast_d, done_q, done_d;
    logic [63:0]      pipe_q [MUL_LAT];
    logic [63:0]      pipe_d [MUL_LAT];

    logic        is_mul, is_div, sgn, accept, fast_go, div_done;
    logic [31:0] abs_a, abs_b, div_quo, div_rem, quo_raw, rem_raw, quo_s, rem_s;
    logic [63:0] prod_s;

    assign is_mul = op_e == MDU_MULT || op_e == MDU_MULTU;
    assign is_div = op_e == MDU_DIV || op_e == MDU_DIVU;
    assign sgn    = op_e == MDU_MULT || op_e == MDU_DIV;
    assign abs_a  = abs32(src_a_e, sgn);
    assign abs_b  = abs32(src_b_e, sgn);
    // done_q keeps the op still sitting in E during DONE from being issued again.
    assign accept = resetn && state_q == S_IDLE && (is_mul || is_div) && !flush_i && !done_q;

`ifdef MDU_DIV_FAST_EN
    assign fast_go = is_div && (src_b_e == '0 || abs_a < abs_b);
`else
    assign fast_go = 1'b0;
`endif

    div_radix2 u_div (
        .clk        (clk),
        .rst_n      (resetn),
        .start_i    (accept && is_div && !fast_go),
        .dividend_i (abs_a),
        .divisor_i  (abs_b),
        .done_o     (div_done),
        .quo_o      (div_quo),
        .rem_o      (div_rem)
    );

    // Early-out divides produce the same raw quotient/remainder the full sequence would.
    assign quo_raw = fast_q ? {32{b_q == '0}} : div_quo;
    assign rem_raw = fast_q ? a_q : div_rem;
    assign quo_s   = neg_quo_q ? -quo_raw : quo_raw;
    assign rem_s   = neg_rem_q ? -rem_raw : rem_raw;
    assign prod_s  = neg_quo_q ? -pipe_q[MUL_LAT-1] : pipe_q[MUL_LAT-1];

    assign hilo_we_o = state_q == S_DONE && !flush_i;
    assign stall_o   = accept || ((state_q == S_MUL || state_q == S_DIV) && !flush_i);
    assign busy_o    = state_q != S_IDLE;
    assign hi_o      = hi_d;
    assign lo_o      = lo_d;

    // Next-state, operand capture and signed result fix-up.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        mul_d     = mul_q;
        fast_d    = fast_q;
        done_d    = state_q == S_DONE;
        hi_d      = hilo_we_o ? (mul_q ? prod_s[63:32] : rem_s) : hi_q;
        lo_d      = hilo_we_o ? (mul_q ? prod_s[31:0] : quo_s) : lo_q;
        pipe_d    = pipe_q;
        case (state_q)
            S_IDLE: if (accept) begin
                a_d       = abs_a;
                b_d       = abs_b;
                neg_quo_d = sgn && (src_a_e[31] ^ src_b_e[31]);
                neg_rem_d = sgn && src_a_e[31];
                mul_d     = is_mul;
                fast_d    = fast_go;
                cnt_d     = '0;
                state_d   = is_mul ? S_MUL : (fast_go ? S_DONE : S_DIV);
            end
            S_MUL: begin
                pipe_d[0] = 64'(a_q) * 64'(b_q);
                for (int i = 1; i < MUL_LAT; i++) pipe_d[i] = pipe_q[i-1];
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = cnt_q == CNT_W'(MUL_LAT - 1) ? S_DONE : S_MUL;
            end
            S_DIV: begin
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = div_done ? S_DONE : S_DIV;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
        if (flush_i) state_d = S_IDLE;
    end

    // Controller registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            mul_q     <= 1'b0;
            fast_q    <= 1'b0;
            done_q    <= 1'b0;
            for (int i = 0; i < MUL_LAT; i++) pipe_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            mul_q     <= mul_d;
            fast_q    <= fast_d;
            done_q    <= done_d;
            pipe_q    <= pipe_d;
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed and random checks of mdu_ctrl against an arithmetic reference model.
module tb_mdu_ctrl;

    localparam int MUL_LAT = 2;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [2:0]  op_e = 3'd0;
    logic [31:0] src_a_e = '0;
    logic [31:0] src_b_e = '0;
    logic        flush_i = 1'b0;
    logic        stall_o, hilo_we_o, busy_o;
    logic [31:0] hi_o, lo_o;

    int tests = 0;
    int fails = 0;

    mdu_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .op_e      (op_e),
        .src_a_e   (src_a_e),
        .src_b_e   (src_b_e),
        .flush_i   (flush_i),
        .stall_o   (stall_o),
        .hilo_we_o (hilo_we_o),
        .hi_o      (hi_o),
        .lo_o      (lo_o),
        .busy_o    (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Architectural results from plain 64-bit arithmetic, plus expected stall length.
    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo, output int st);
        longint sa, sb, q, r;
        logic [63:0] p;
        logic [31:0] aa, bb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        aa = (op == 3'd3 && a[31]) ? -a : a;
        bb = (op == 3'd3 && b[31]) ? -b : b;
        st = 33;
`ifdef MDU_DIV_FAST_EN
        if (op >= 3'd3 && (b == 0 || aa < bb)) st = 1;
`endif
        if (op == 3'd1) begin
            p  = 64'(sa * sb);
            st = MUL_LAT + 1;
        end else if (op == 3'd2) begin
            p  = {32'd0, a} * {32'd0, b};
            st = MUL_LAT + 1;
        end else if (b == 0) begin
            p = {a, 32'hFFFF_FFFF};
        end else if (op == 3'd3) begin
            q = sa / sb;
            r = sa % sb;
            p = {r[31:0], q[31:0]};
        end else begin
            p = {a % b, a / b};
        end
        hi = p[63:32];
        lo = p[31:0];
    endfunction

    // Issue one op, hold it in E through DONE, and check stall length, write and result.
    task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eh, el;
        int es, n;
        model(op, a, b, eh, el, es);
        op_e = op;
        src_a_e = a;
        src_b_e = b;
        n = 0;
        @(negedge clk);
        while (stall_o === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk({tag, " stall"}, 64'(n), 64'(es));
        chk({tag, " we"}, 64'(hilo_we_o), 64'd1);
        chk({tag, " hi"}, 64'(hi_o), 64'(eh));
        chk({tag, " lo"}, 64'(lo_o), 64'(el));
        @(posedge clk); #1;
        chk({tag, " norestart"}, {61'd0, busy_o, stall_o, hilo_we_o}, 64'd0);
        op_e = 3'd0;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset", {stall_o, busy_o, hilo_we_o, hi_o, lo_o}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;

        // directed cases
        run("mult_neg", 3'd1, 32'hFFFF_FFFD, 32'd7);
        run("divu_100_7", 3'd4, 32'd100, 32'd7);
        run("div_neg7_2", 3'd3, 32'hFFFF_FFF9, 32'd2);
        run("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        run("divu_by0", 3'd4, 32'h1234, 32'd0);
        run("divu_small", 3'd4, 32'd5, 32'd9);
        run("multu_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // unused op encoding is treated as NONE
        op_e = 3'd6;
        @(negedge clk);
        chk("badop stall", 64'(stall_o), 64'd0);
        @(posedge clk); #1;
        chk("badop busy", 64'(busy_o), 64'd0);
        op_e = 3'd0;

        // flush mid-divide, then a fresh multiply
        op_e = 3'd3;
        src_a_e = 32'd1000;
        src_b_e = 32'd3;
        @(posedge clk); #1;
        repeat (10) @(posedge clk);
        #1;
        flush_i = 1'b1;
        #1;
        chk("flush stall", {62'd0, stall_o, hilo_we_o}, 64'd0);
        @(posedge clk); #1;
        flush_i = 1'b0;
        op_e = 3'd0;
        #1;
        chk("flush idle", {61'd0, busy_o, stall_o, hilo_we_o}, 64'd0);
        @(posedge clk); #1;
        run("multu_2_3", 3'd2, 32'd2, 32'd3);

        // flush in DONE suppresses the write and leaves HI/LO as they were
        op_e = 3'd1;
        src_a_e = 32'd5;
        src_b_e = 32'd6;
        repeat (MUL_LAT + 1) @(posedge clk);
        #1;
        flush_i = 1'b1;
        #1;
        chk("flushdone we", 64'(hilo_we_o), 64'd0);
        chk("flushdone hilo", {hi_o, lo_o}, 64'd6);
        @(posedge clk); #1;
        flush_i = 1'b0;
        op_e = 3'd0;
        chk("flushdone idle", 64'(busy_o), 64'd0);
        @(posedge clk); #1;
        chk("flushdone hold", {hi_o, lo_o}, 64'd6);

        // async reset in the middle of a divide
        op_e = 3'd4;
        src_a_e = 32'd123456;
        src_b_e = 32'd7;
        repeat (21) @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        chk("rst mid", {stall_o, busy_o, hilo_we_o, hi_o, lo_o}, 64'd0);
        op_e = 3'd0;
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst after", {62'd0, busy_o, hilo_we_o}, 64'd0);
        end

        // random ops against the model
        for (int i = 0; i < 20; i++) begin
            rop = 3'($urandom_range(1, 4));
            ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            if (rop == 3'd3 && rb == 0) rb = 32'd1;
            run("rand", rop, ra, rb);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
Multi-cycle multiply/divide sequencer for the E stage of the 5-stage MIPS pipeline.
- Accepts MULT/MULTU/DIV/DIVU from E.
- Runs a pipelined multiplier or an iterative radix-2 divider.
- Drives the E-stage mul/div stall (feeds the hazard unit's mut_div_stallE input).
- Issues a one-cycle HI/LO write with the 64-bit result.

Parameters:
MUL_LAT, 2, multiplier latency in cycles (1..4); the product is registered MUL_LAT times.
DIV_ITER, 32, divider iterations (one quotient bit per cycle); fixed to data width.

Ports:
clk  in  1  pipeline clock, rising edge
resetn  in  1  asynchronous active-low reset
op_e  in  3  E-stage op: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU; others treated as NONE
src_a_e  in  32  rs operand (already forwarded)
src_b_e  in  32  rt operand (already forwarded)
flush_i  in  1  abort in-flight op (exception/flushE)
stall_o  out  1  E-stage mul/div stall request
hilo_we_o  out  1  HI/LO write strobe, one cycle
hi_o  out  32  HI result (remainder / product[63:32])
lo_o  out  32  LO result (quotient / product[31:0])
busy_o  out  1  state != IDLE

Behaviour:
- Reset: all outputs 0. State=IDLE, counter=0, operand/result registers 0.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - op_e valid and flush_i=0: latch operands and op at the clock edge, go to MUL or DIV.
  - stall_o = 1 combinationally in this same cycle, so D and E hold.
- Signed ops:
  - Latch absolute values.
  - Record neg_q = a[31]^b[31] and neg_r = a[31].
  - Quotient and product take neg_q. Remainder takes neg_r (two's-complement fix-up in the DONE cycle).
  - -2^31 / -1 yields quotient 0x80000000, remainder 0.
- MUL:
  - Counter counts 0..MUL_LAT-1. stall_o=1.
  - Go to DONE after MUL_LAT cycles.
  - Total stall for a MUL = MUL_LAT+1 cycles, counting the IDLE issue cycle.
- DIV:
  - Restoring shift-subtract, one quotient bit per cycle. Counter 0..31. stall_o=1.
  - Go to DONE after 32 iterations; total stall = 33 cycles.
- DONE:
  - stall_o=0, hilo_we_o=1, hi_o/lo_o hold the final signed-corrected result.
  - Next state is always IDLE.
  - The E instruction still presents op_e in this cycle. The held op must not restart: IDLE acceptance is blocked for the cycle after DONE via a one-cycle done_q flag.
- hi_o/lo_o hold their last value after DONE; hilo_we_o is 0 outside DONE.
- Divide by zero (not architecturally trapped): result hi=dividend, lo=0xFFFFFFFF (natural restoring result, before sign fix-up). Full 33-cycle latency.
- flush_i in any state:
  - Go to IDLE next edge, stall_o=0 that cycle, no hilo write.
  - In IDLE, flush_i blocks acceptance.
- flush_i in DONE: suppresses hilo_we_o.
- Async reset mid-operation: immediate IDLE, outputs 0, no write.
- Back-to-back mul/div ops: the second is accepted in the cycle after the done_q block clears. Each op gets an independent full sequence.

Optional Feature:
MDU_DIV_FAST_EN:
- Defined: in IDLE, a DIV/DIVU with src_b=0 or |a|<|b| goes straight to DONE.
  - Stall = 1 cycle.
  - Results: b=0 gives hi=a, lo=0xFFFFFFFF. |a|<|b| gives hi=a, lo=0.
- Undefined: every divide takes the full 33-cycle sequence. Results are bit-identical either way.

Decomposition:
Shared package (mdu_pkg):
- op encodings MDU_NONE/MULT/MULTU/DIV/DIVU.
- State enum.
- DIV_ITER constant.

Sub-module div_radix2:
- Iterative unsigned divider.
- Interface: start, abs operands, done pulse, quotient/remainder.
- mdu_ctrl owns the FSM, sign handling, multiplier pipeline and stall generation.

Test Plan:
- MULT a=-3 (0xFFFFFFFD), b=7, MUL_LAT=2 -> stall_o high 3 cycles, then hilo_we_o=1 with hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIVU a=100, b=7 -> stall_o high 33 cycles, then hilo_we_o pulse with lo=14, hi=2; op still on op_e in the DONE cycle is not restarted.
- DIV a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIV 0x80000000 / -1 -> lo=0x80000000, hi=0.
- DIVU b=0, a=0x1234 -> without macro: 33-cycle stall, hi=0x1234, lo=0xFFFFFFFF; with MDU_DIV_FAST_EN: 1-cycle stall, same values.
- DIV started, flush_i at iteration 10 -> next cycle stall_o=0, busy_o=0, no hilo_we_o; new MULTU 2*3 then completes with lo=6.
- resetn low during DIV iteration 20 -> outputs 0 immediately; after release, IDLE with no spurious write.
